// File: rtl/alu_pkg.sv
// Shared constants for the integer ALU: datapath width and MIPS funct encodings.
package alu_pkg;

  localparam int WIDTH = 32;

  localparam logic [5:0] ALU_ADD  = 6'b100000;
  localparam logic [5:0] ALU_ADDU = 6'b100001;
  localparam logic [5:0] ALU_SUB  = 6'b100010;
  localparam logic [5:0] ALU_SUBU = 6'b100011;
  localparam logic [5:0] ALU_AND  = 6'b100100;
  localparam logic [5:0] ALU_OR   = 6'b100101;
  localparam logic [5:0] ALU_XOR  = 6'b100110;
  localparam logic [5:0] ALU_NOR  = 6'b100111;
  localparam logic [5:0] ALU_SLL  = 6'b000000;
  localparam logic [5:0] ALU_SRL  = 6'b000010;
  localparam logic [5:0] ALU_SRA  = 6'b000011;
  localparam logic [5:0] ALU_SLLV = 6'b000100;
  localparam logic [5:0] ALU_SRLV = 6'b000110;
  localparam logic [5:0] ALU_SRAV = 6'b000111;
  localparam logic [5:0] ALU_SLT  = 6'b101010;
  localparam logic [5:0] ALU_SLTU = 6'b101011;

endpackage

// File: rtl/alu_shifter.sv
// Combinational barrel shifter: left, logical right or arithmetic right by shamt.
module alu_shifter #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] data,
  input  logic [SHW-1:0]   shamt,
  input  logic             dir,
  input  logic             arith,
  output logic [WIDTH-1:0] result
);

  // dir=0 shifts left; dir=1 shifts right, sign-filling when arith=1
  always_comb begin
    result = '0;
    if (!dir)
      result = data << shamt;
    else if (arith)
      result = WIDTH'($signed(data) >>> shamt);
    else
      result = data >> shamt;
  end

endmodule

// File: rtl/alu.sv
// 32-bit MIPS-style integer ALU selected by funct code; result and flags
// are registered, giving exactly one cycle of latency.
module alu
  import alu_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in1,
  input  logic [W-1:0] in2,
  input  logic [5:0]   Con,
  output logic [W-1:0] out,
  output logic         zero,
  output logic         ovf
);

  localparam int SHW = $clog2(W);

  logic [W-1:0] sum, diff, sh_res, res;
  logic         add_ovf, sub_ovf, ovf_c;
  logic         slt_s, slt_u;

  assign sum  = in1 + in2;
  assign diff = in1 - in2;

  // Signed overflow: operand signs agree (add) / differ (sub) and the result sign flips
  assign add_ovf = (in1[W-1] == in2[W-1]) && (sum[W-1]  != in1[W-1]);
  assign sub_ovf = (in1[W-1] != in2[W-1]) && (diff[W-1] != in1[W-1]);

  assign slt_s = $signed(in1) < $signed(in2);
  assign slt_u = in1 < in2;

  // Shift funct codes encode direction in bit 1 and arithmetic fill in bit 0
  alu_shifter #(.WIDTH(W), .SHW(SHW)) u_shifter (
    .data   (in2),
    .shamt  (in1[SHW-1:0]),
    .dir    (Con[1]),
    .arith  (Con[0]),
    .result (sh_res)
  );

  always_comb begin
    res   = '0;
    ovf_c = 1'b0;
    case (Con)
      ALU_ADD:  begin res = sum;  ovf_c = add_ovf; end
      ALU_ADDU: res = sum;
      ALU_SUB:  begin res = diff; ovf_c = sub_ovf; end
      ALU_SUBU: res = diff;
      ALU_AND:  res = in1 & in2;
      ALU_OR:   res = in1 | in2;
      ALU_XOR:  res = in1 ^ in2;
      ALU_NOR:  res = ~(in1 | in2);
      ALU_SLL, ALU_SRL, ALU_SRA,
      ALU_SLLV, ALU_SRLV, ALU_SRAV: res = sh_res;
      ALU_SLT:  res = {{(W-1){1'b0}}, slt_s};
      ALU_SLTU: res = {{(W-1){1'b0}}, slt_u};
      default:  begin res = '0; ovf_c = 1'b0; end
    endcase
  end

  // zero is taken from the fresh result, so it always matches the value registered into out
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out  <= '0;
      zero <= 1'b1;
      ovf  <= 1'b0;
    end else begin
      out  <= res;
      zero <= (res == '0);
      ovf  <= ovf_c;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for alu: hand-computed results and flags checked one cycle after issue.
module tb_alu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in1, in2;
  logic [5:0]  Con;
  logic [31:0] out;
  logic        zero, ovf;

  int n_run  = 0;
  int n_fail = 0;

  alu dut (
    .clk  (clk),
    .rst_n(rst_n),
    .in1  (in1),
    .in2  (in2),
    .Con  (Con),
    .out  (out),
    .zero (zero),
    .ovf  (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drive one op, clock it, then check the registered result just after the edge
  task automatic op(input string tag, input logic [5:0] c, input logic [31:0] a,
                    input logic [31:0] b, input logic [31:0] e_out,
                    input logic e_zero, input logic e_ovf);
    Con = c; in1 = a; in2 = b;
    @(posedge clk); #1;
    chk({tag, ".out"},  out,          e_out);
    chk({tag, ".zero"}, {31'b0, zero}, {31'b0, e_zero});
    chk({tag, ".ovf"},  {31'b0, ovf},  {31'b0, e_ovf});
  endtask

  initial begin
    rst_n = 1'b0; in1 = 32'd5; in2 = 32'd3; Con = 6'b100000;
    @(posedge clk); #1;
    chk("rst.out",  out,          32'h0);
    chk("rst.zero", {31'b0, zero}, 32'h1);
    chk("rst.ovf",  {31'b0, ovf},  32'h0);
    rst_n = 1'b1;

    // in1=5, in2=3 basic table
    op("add",  6'b100000, 32'd5, 32'd3, 32'd8, 1'b0, 1'b0);
    op("addu", 6'b100001, 32'd5, 32'd3, 32'd8, 1'b0, 1'b0);
    op("and",  6'b100100, 32'd5, 32'd3, 32'd1, 1'b0, 1'b0);
    op("or",   6'b100101, 32'd5, 32'd3, 32'd7, 1'b0, 1'b0);
    op("xor",  6'b100110, 32'd5, 32'd3, 32'd6, 1'b0, 1'b0);
    op("sub",  6'b100010, 32'd5, 32'd3, 32'd2, 1'b0, 1'b0);
    op("subu", 6'b100011, 32'd5, 32'd3, 32'd2, 1'b0, 1'b0);
    op("sll",  6'b000000, 32'd5, 32'd3, 32'd96, 1'b0, 1'b0);
    op("sllv", 6'b000100, 32'd5, 32'd3, 32'd96, 1'b0, 1'b0);
    op("srl",  6'b000010, 32'd5, 32'd3, 32'd0, 1'b1, 1'b0);
    op("sra",  6'b000011, 32'd5, 32'd3, 32'd0, 1'b1, 1'b0);
    op("srlv", 6'b000110, 32'd5, 32'd3, 32'd0, 1'b1, 1'b0);
    op("slt",  6'b101010, 32'd5, 32'd3, 32'd0, 1'b1, 1'b0);
    op("sltu", 6'b101011, 32'd5, 32'd3, 32'd0, 1'b1, 1'b0);
    op("slt2", 6'b101010, 32'd3, 32'd5, 32'd1, 1'b0, 1'b0);

    // Overflow boundaries
    op("add_ovf",  6'b100000, 32'h7FFFFFFF, 32'd1, 32'h80000000, 1'b0, 1'b1);
    op("addu_ovf", 6'b100001, 32'h7FFFFFFF, 32'd1, 32'h80000000, 1'b0, 1'b0);
    op("sub_ovf",  6'b100010, 32'h80000000, 32'd1, 32'h7FFFFFFF, 1'b0, 1'b1);
    op("subu_ovf", 6'b100011, 32'h80000000, 32'd1, 32'h7FFFFFFF, 1'b0, 1'b0);
    op("add_wrap", 6'b100000, 32'hFFFFFFFF, 32'd1, 32'h0,        1'b1, 1'b0);
    op("sub_neg",  6'b100010, 32'hFFFFFFFE, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 1'b1);

    // Signed vs unsigned compare
    op("slt_m1",  6'b101010, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0, 1'b0);
    op("sltu_m1", 6'b101011, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b1, 1'b0);

    // Shifts: sign fill, upper in1 bits ignored, shift by 0 and 31
    op("sra_neg",  6'b000011, 32'd4,        32'h80000000, 32'hF8000000, 1'b0, 1'b0);
    op("srav_hi",  6'b000111, 32'hFFFFFFE4, 32'h80000000, 32'hF8000000, 1'b0, 1'b0);
    op("srlv_neg", 6'b000110, 32'd4,        32'h80000000, 32'h08000000, 1'b0, 1'b0);
    op("sll_0",    6'b000000, 32'hFFFFFFE0, 32'h12345678, 32'h12345678, 1'b0, 1'b0);
    op("sll_31",   6'b000100, 32'd31,       32'd1,        32'h80000000, 1'b0, 1'b0);
    op("sra_pos",  6'b000011, 32'd31,       32'h7FFFFFFF, 32'h0,        1'b1, 1'b0);

    // Logic edge + undefined functs
    op("nor0",  6'b100111, 32'h0, 32'h0, 32'hFFFFFFFF, 1'b0, 1'b0);
    op("bad3f", 6'b111111, 32'd5, 32'd3, 32'h0, 1'b1, 1'b0);
    op("bad01", 6'b000001, 32'h7FFFFFFF, 32'd1, 32'h0, 1'b1, 1'b0);

    // Latency: inputs change, out holds until the next edge
    op("lat_a", 6'b100000, 32'd5, 32'd3, 32'd8, 1'b0, 1'b0);
    Con = 6'b100101; in1 = 32'hF0; in2 = 32'h0F;
    #2;
    chk("lat_hold", out, 32'd8);
    @(posedge clk); #1;
    chk("lat_new", out, 32'hFF);

    // Reset mid-stream overrides an overflowing ADD, then release resumes
    Con = 6'b100000; in1 = 32'h7FFFFFFF; in2 = 32'd1; rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mrst.out",  out,          32'h0);
    chk("mrst.zero", {31'b0, zero}, 32'h1);
    chk("mrst.ovf",  {31'b0, ovf},  32'h0);
    rst_n = 1'b1;
    op("resume", 6'b100000, 32'h7FFFFFFF, 32'd1, 32'h80000000, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
